// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  ready, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, done, s, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - multi-cycle adder reusing one 4-bit ripple slice per nibble, LSB first
// Optional subtract mode enabled by defining NIBBLE_SERIAL_SUB_EN.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    nibble_serial_add_ctrl_if.slave  bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ready_q;
    logic             done_q;

    logic             inv_b;
    logic             eff_cin;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       slice_sum;
    logic [4:0]       slice_c;

`ifdef NIBBLE_SERIAL_SUB_EN
    logic sub_q;
    assign inv_b   = sub_q;
    assign eff_cin = bus.sub ? 1'b1 : bus.cin;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign inv_b      = 1'b0;
    assign eff_cin    = bus.cin;
`endif

    // The only adder in the block: four full adders fed by the nibble selected by idx_q.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
        b_nib      = b_nib ^ {4{inv_b}};
        slice_c    = '0;
        slice_c[0] = carry_q;
        slice_sum  = '0;
        for (int k = 0; k < 4; k++) begin
            slice_sum[k]  = a_nib[k] ^ b_nib[k] ^ slice_c[k];
            slice_c[k+1]  = (a_nib[k] & b_nib[k]) | (slice_c[k] & (a_nib[k] ^ b_nib[k]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx_q   <= '0;
                        carry_q <= eff_cin;
                        s_q     <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
`ifdef NIBBLE_SERIAL_SUB_EN
                        sub_q   <= bus.sub;
`endif
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (idx_q == IDX_W'(n)) begin
                            s_q[4*n +: 4] <= slice_sum;
                        end
                    end
                    carry_q <= slice_c[4];
                    // Index returns to zero rather than counting past the top nibble.
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        cout_q  <= slice_c[4];
                        ovf_q   <= slice_c[3] ^ slice_c[4];
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - vector table, random model comparison and corner sequences for the nibble-serial adder
module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] bb;
        logic        c;
        logic [16:0] sum;
        logic        ov;
        bb = mb;
        c  = mcin;
`ifdef NIBBLE_SERIAL_SUB_EN
        if (msub) begin
            bb = ~mb;
            c  = 1'b1;
        end
`else
        if (msub) bb = mb;
`endif
        sum = {1'b0, ma} + {1'b0, bb} + {16'd0, c};
        ov  = (ma[15] == bb[15]) && (sum[15] != ma[15]);
        return {ov, sum[16], sum[15:0]};
    endfunction

    // Accept on the next edge, then wait for done; lat counts edges after the accept edge.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                         input logic tsub, output logic [15:0] rs, output logic rc,
                         output logic ro, output int lat, output int rlow);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.cin = tcin; bus.sub = tsub;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        lat = 0;
        rlow = bus.ready ? 0 : 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!bus.done && !bus.ready) rlow++;
        end
        rs = bus.s; rc = bus.cout; ro = bus.ovf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rs;
        logic        rc, ro;
        int          lat, rlow;
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rcin, rsub;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`ifdef NIBBLE_SERIAL_SUB_EN
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0};
`else
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
        vecs[6] = '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0};
`endif

        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.ready), 32'd1);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_s", 32'(bus.s), 32'd0);
        chk("reset_cout", 32'(bus.cout), 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat, rlow);
            chk($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_ready_low", i), 32'(rlow), 32'd4);
        end

        // Result holds through idle cycles and done does not repeat.
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold_s", 32'(bus.s), 32'(vecs[6].s));
            chk("hold_cout", 32'(bus.cout), 32'(vecs[6].cout));
            chk("hold_done", 32'(bus.done), 32'd0);
            chk("hold_ready", 32'(bus.ready), 32'd1);
        end

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rcin = 1'($urandom); rsub = 1'($urandom);
            m = model(ra, rb, rcin, rsub);
            do_op(ra, rb, rcin, rsub, rs, rc, ro, lat, rlow);
            chk($sformatf("rand%0d_s", i), 32'(rs), 32'(m[15:0]));
            chk($sformatf("rand%0d_cout", i), 32'(rc), 32'(m[16]));
            chk($sformatf("rand%0d_ovf", i), 32'(ro), 32'(m[17]));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd4);
        end

        // Start during RUN is ignored; start held through DONE re-accepts at once.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'hAAAA;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("run_start_ignored_ready", 32'(bus.ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_first_done", 32'(bus.done), 32'd1);
        chk("b2b_first_s", 32'(bus.s), 32'h3333);
        bus.start = 1'b1; bus.a = 16'h0101; bus.b = 16'h0202; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_accept_ready", 32'(bus.ready), 32'd0);
        chk("b2b_accept_done", 32'(bus.done), 32'd0);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd4);
        chk("b2b_second_s", 32'(bus.s), 32'h0303);

        // Leave cout=1 behind, then reset in the 2nd RUN cycle of the next op.
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat, rlow);
        chk("pre_reset_cout", 32'(rc), 32'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrun_reset_ready", 32'(bus.ready), 32'd1);
        chk("midrun_reset_done", 32'(bus.done), 32'd0);
        chk("midrun_reset_s", 32'(bus.s), 32'd0);
        chk("midrun_reset_cout", 32'(bus.cout), 32'd0);
        chk("midrun_reset_ovf", 32'(bus.ovf), 32'd0);
        rlow = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) rlow++;
        end
        chk("midrun_reset_no_done", 32'(rlow), 32'd0);

        // Reset wins over start on the same edge.
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101;
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        chk("reset_priority_ready", 32'(bus.ready), 32'd1);
        chk("reset_priority_s", 32'(bus.s), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a multiple of 4, at least 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only while ready=1.
REQ-005 a  input  WIDTH  operand A; captured on accept.
REQ-006 b  input  WIDTH  operand B; captured on accept.
REQ-007 cin  input  1  carry-in to the least-significant nibble; captured on accept.
REQ-008 sub  input  1  subtract request; captured on accept; honoured only per REQ-026.
REQ-009 ready  output  1  high in IDLE and DONE; an operation may be accepted.
REQ-010 done  output  1  single-cycle pulse; result valid.
REQ-011 s  output  WIDTH  result sum, held from done until the next accept.
REQ-012 cout  output  1  carry out of the most-significant bit, held with s.
REQ-013 ovf  output  1  signed overflow (carry into MSB XOR cout), held with s.

Function
REQ-014 The block SHALL compute A+B+cin by reusing one internal 4-bit ripple-carry slice (four full adders) once per nibble, LSB nibble first; no WIDTH-bit adder is permitted.
REQ-015 FSM states: IDLE, RUN, DONE; encoding free.
REQ-016 Accept: a rising edge with ready=1 and start=1 latches a, b, cin, sub, clears the nibble index and carry register to the effective cin, clears the s register, and enters RUN.
REQ-017 RUN: each edge SHALL write slice sum into s[4i+3:4i] for nibble index i, store the slice carry-out in the carry register, and increment i.
REQ-018 After the edge processing nibble WIDTH/4-1, the FSM SHALL enter DONE; cout takes the final carry, and ovf takes the carry into bit WIDTH-1 XOR the final carry.
REQ-019 Latency: done SHALL be high in the cycle after edge WIDTH/4 counted from the accept edge (edge 0), i.e. 4 RUN cycles for WIDTH=16.
REQ-020 DONE lasts exactly one cycle; with start=0 the next state is IDLE; with start=1 that edge is an accept (back-to-back operation, no idle bubble).
REQ-021 start while in RUN (ready=0) SHALL be ignored and not queued; operands on a, b, cin, sub are don't-care during RUN.
REQ-022 s, cout, ovf SHALL remain stable from DONE until the next accept edge; they are undefined-but-stable (partial) during RUN.
REQ-023 Nibble index wrap: the index SHALL never exceed WIDTH/4-1; the index register is not reused after DONE without an accept.

Reset
REQ-024 reset=1 at any edge, including mid-RUN, SHALL force IDLE and set ready=1, done=0, s=0, cout=0, ovf=0, carry register=0, and index=0; the in-flight operation is discarded.
REQ-025 reset SHALL take priority over start on the same edge.

Configuration
REQ-026 Macro NIBBLE_SERIAL_SUB_EN: when defined, a latched sub=1 SHALL invert B at each slice input and force the effective carry-in to 1 (result A-B, cout=1 meaning no borrow); cin is ignored for that operation.
REQ-027 Without NIBBLE_SERIAL_SUB_EN: the sub port SHALL exist but be ignored; every operation is A+B+cin.

Verification
REQ-028 WIDTH=16, a=0x1234, b=0x4321, cin=0, start one cycle -> ready low 4 cycles; done pulse on cycle 5; s=0x5555, cout=0, ovf=0.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0000, cin=1 -> s=0x8000, cout=0, ovf=1.
REQ-030 With SUB_EN: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0; without SUB_EN, same inputs with cin=0 -> s=0x000C, cout=0.
REQ-031 Accept 0x1111+0x2222; pulse start with a=0xAAAA during RUN -> ignored; done gives s=0x3333; start held high through DONE -> new accept with no IDLE cycle.
REQ-032 reset asserted on the 2nd RUN cycle -> next cycle: IDLE, ready=1, done=0, s=0, cout=0, ovf=0; no later done pulse.
